// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 1 bit per cycle shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied when the result is written.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero,
    output logic                 stallreq
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     b_mag;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_cand;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   acc_next;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Product negated as a whole; quotient and remainder corrected independently.
    function automatic logic [2*WIDTH-1:0] fix_sign(input logic [2*WIDTH-1:0] raw,
                                                    input logic div, input logic nq,
                                                    input logic nr);
        logic signed [2*WIDTH-1:0] prod;
        logic signed [WIDTH-1:0]   quo;
        logic signed [WIDTH-1:0]   rem;
        prod = nq ? -$signed(raw) : $signed(raw);
        quo  = nq ? -$signed(raw[WIDTH-1:0]) : $signed(raw[WIDTH-1:0]);
        rem  = nr ? -$signed(raw[2*WIDTH-1:WIDTH]) : $signed(raw[2*WIDTH-1:WIDTH]);
        return div ? {rem, quo} : prod;
    endfunction

    // acc holds {hi, lo}: product accumulator / multiplier, or remainder / quotient.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
        rem_cand = acc[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_cand - {1'b0, b_mag};
        if (is_div) begin
            if (!rem_diff[WIDTH])
                acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

    assign stallreq = resetn & (((state == IDLE) & start & ~annul) | (state == CALC));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            b_mag       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start && !annul) begin
                        if (op[1] && (src2 == '0)) begin
                            state       <= DONE;
                            ready       <= 1'b1;
                            result      <= {src1, {WIDTH{1'b1}}};
                            div_by_zero <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            acc    <= {{WIDTH{1'b0}}, mag(src1, op[0])};
                            b_mag  <= mag(src2, op[0]);
                            is_div <= op[1];
                            neg_q  <= op[0] & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                            neg_r  <= op[1] & op[0] & src1[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    if (annul) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            ready       <= 1'b1;
                            result      <= fix_sign(acc_next, is_div, neg_q, neg_r);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with a cycle-level reference model
// and per-cycle output comparison.
module tb_muldiv_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic        annul;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        ready;
    logic [63:0] result;
    logic        div_by_zero;
    logic        stallreq;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .annul(annul),
        .src1(src1), .src2(src2), .busy(busy), .ready(ready), .result(result),
        .div_by_zero(div_by_zero), .stallreq(stallreq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: return 64'(sa * sb);
            2'b10: return {a % b, a / b};
            default: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Reference model: cycles of work left, a done flag, and the visible result.
    int          m_left = 0;
    bit          m_done = 0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_pend = '0;
    bit          m_dbz  = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left = 0; m_done = 0; m_res = '0; m_dbz = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            if (annul) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_res = m_pend; m_dbz = 0;
                end
            end
        end else if (start && !annul) begin
            if (op[1] && src2 == 32'd0) begin
                m_done = 1; m_res = {src1, 32'hFFFF_FFFF}; m_dbz = 1;
            end else begin
                m_left = 32;
                m_pend = ref_calc(op, src1, src2);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp busy", 64'(busy), 64'(m_left > 0));
            chk("cmp ready", 64'(ready), 64'(m_done));
            chk("cmp result", result, m_res);
            chk("cmp div_by_zero", 64'(div_by_zero), 64'(m_dbz));
            chk("cmp stallreq", 64'(stallreq),
                64'(resetn && ((m_left == 0 && !m_done && start && !annul) || m_left > 0)));
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat,
                          input bit exp_dbz, input bit hold_start, input int annul_at);
        int lat;
        int stall_n;
        lat = -1;
        stall_n = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; src1 = a; src2 = b; annul = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (stallreq) stall_n++;
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
            start = hold_start;
            src1  = $urandom;
            src2  = $urandom;
            op    = 2'($urandom);
            annul = (c + 1 == annul_at);
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, result, exp_res);
        chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        chk({name, " stall cycles"}, 64'(stall_n), 64'(exp_lat));
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
    endtask

    initial begin
        int readies;
        int lat;
        resetn = 1'b0; start = 1'b1; op = 2'b00; annul = 1'b0; src1 = '0; src2 = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
        chk("reset stallreq", 64'(stallreq), 64'd0);
        start = 1'b0;
        resetn = 1'b1;
        cmp_en = 1;

        run_op("smul -3*5", 2'b01, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 33, 0, 0, -1);
        run_op("sdiv -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, 0, -1);
        run_op("udiv 100/0", 2'b10, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1, 1, 0, -1);
        run_op("sdiv ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 0, 0, -1);

        // Annul in cycle 10, then a new start in cycle 11.
        readies = 0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; src1 = 32'd3; src2 = 32'd4; annul = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0; annul = (c == 10);
            @(negedge clk);
            if (ready) readies++;
        end
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b1; op = 2'b00; src1 = 32'd6; src2 = 32'd7;
        @(negedge clk);
        chk("annul busy low", 64'(busy), 64'd0);
        chk("annul no ready", 64'(readies + int'(ready)), 64'd0);
        chk("annul result kept", result, 64'h0000_0000_8000_0000);
        lat = -1;
        for (int c = 12; c < 60; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (ready) begin
                lat = c - 11;
                break;
            end
        end
        chk("restart latency", 64'(lat), 64'd33);
        chk("restart result", result, 64'd42);
        @(posedge clk); #1;

        run_op("umul max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 0, 1, -1);
        run_op("udiv annul done", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 0, 0, 33);
        run_op("sdiv 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 0, 0, -1);
        run_op("smul minneg", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 0, 0, -1);
        run_op("udiv 5/9", 2'b10, 32'd5, 32'd9, 64'h0000_0005_0000_0000, 33, 0, 0, -1);
        run_op("sdiv by 0", 2'b11, 32'h8000_0000, 32'd0, 64'h8000_0000_FFFF_FFFF, 1, 1, 0, -1);

        // start together with annul in IDLE is not accepted.
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; op = 2'b00; src1 = 32'd9; src2 = 32'd9;
        @(negedge clk);
        chk("start+annul stallreq", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        @(negedge clk);
        chk("start+annul busy", 64'(busy), 64'd0);

        // Asynchronous reset in cycle 15 of a division.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; src1 = 32'd1000; src2 = 32'd7;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        chk("pre-reset busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("async busy", 64'(busy), 64'd0);
        chk("async ready", 64'(ready), 64'd0);
        chk("async result", result, 64'd0);
        chk("async div_by_zero", 64'(div_by_zero), 64'd0);
        chk("async stallreq", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        readies = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) readies++;
        end
        chk("post-reset no ready", 64'(readies), 64'd0);
        chk("post-reset result", result, 64'd0);

        // First edge after release accepts start.
        @(posedge clk); #1;
        resetn = 1'b0;
        #2;
        resetn = 1'b1; start = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("first edge accept", 64'(busy), 64'd1);
        lat = -1;
        for (int c = 2; c < 60; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (ready) begin
                lat = c;
                break;
            end
        end
        chk("first edge latency", 64'(lat), 64'd33);
        chk("first edge result", result, 64'd6);
        @(posedge clk); #1;
        @(negedge clk);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
